// File: rtl/sprite_pkg.sv
// Shared sprite/compositor constants, collision bit positions and motion FSM encoding.
package sprite_pkg;

  localparam int SPRITE_SIZE = 16;
  localparam int BG_SIZE_X   = 1000;
  localparam int BG_SIZE_Y   = 1000;
  localparam int COORD_W     = 10;
  // Signed working width: holds pos + STEP and pos - STEP without wrap
  localparam int CALC_W      = 12;
  localparam int DIV_W       = 8;

  localparam int COL_RIGHT  = 0;
  localparam int COL_LEFT   = 1;
  localparam int COL_BOTTOM = 2;
  localparam int COL_TOP    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    CLAMP  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/axis_step_clamp.sv
// One sprite axis: signed step in CALC, saturate to [0, MAX] in CLAMP, edge flags from the result.
module axis_step_clamp #(
  parameter int MAX  = 984,
  parameter int STEP = 2
) (
  input  logic                           clk,
  input  logic                           calc_en,
  input  logic                           clamp_en,
  input  logic [sprite_pkg::COORD_W-1:0] pos,
  input  logic                           inc,
  input  logic                           dec,
  output logic [sprite_pkg::COORD_W-1:0] pos_clamped,
  output logic                           at_max,
  output logic                           at_min
);
  import sprite_pkg::*;

  localparam logic signed [CALC_W-1:0] STEP_S = CALC_W'(STEP);
  localparam logic signed [CALC_W-1:0] MAX_S  = CALC_W'(MAX);

  function automatic logic [COORD_W-1:0] sat(input logic signed [CALC_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_S)
      return COORD_W'(MAX);
    else
      return v[COORD_W-1:0];
  endfunction

  logic signed [CALC_W-1:0] dx;
  logic signed [CALC_W-1:0] sum_p1;
  logic [COORD_W-1:0]       pos_p2;

  // Opposing requests cancel rather than favour one side
  always_comb begin
    dx = '0;
    if (inc && !dec)
      dx = STEP_S;
    else if (dec && !inc)
      dx = -STEP_S;
  end

  // Stage p1: unclamped signed sum
  always_ff @(posedge clk) begin
    if (calc_en)
      sum_p1 <= $signed({2'b00, pos}) + dx;
  end

  // Stage p2: saturated coordinate
  always_ff @(posedge clk) begin
    if (clamp_en)
      pos_p2 <= sat(sum_p1);
  end

  assign pos_clamped = pos_p2;
  assign at_max      = (pos_p2 == COORD_W'(MAX));
  assign at_min      = (pos_p2 == '0);

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: divided frame ticks drive an IDLE/CALC/CLAMP/COMMIT update.
module sprite_motion_ctrl #(
  parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE,
  parameter int BG_SIZE_X   = sprite_pkg::BG_SIZE_X,
  parameter int BG_SIZE_Y   = sprite_pkg::BG_SIZE_Y,
  parameter int STEP        = 2,
  parameter int FRAME_DIV   = 1,
  parameter int INIT_X      = 492,
  parameter int INIT_Y      = 492
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           frame_tick,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_up,
  input  logic                           btn_down,
  output logic [sprite_pkg::COORD_W-1:0] pos_x,
  output logic [sprite_pkg::COORD_W-1:0] pos_y,
  output logic [3:0]                     collision,
  output logic                           update_done,
  output logic                           overrun
);
  import sprite_pkg::*;

  localparam int XMAX = BG_SIZE_X - SPRITE_SIZE;
  localparam int YMAX = BG_SIZE_Y - SPRITE_SIZE;

  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_last;
  logic               tick_qual;
  logic               accept;
  logic               vld_p0;
  logic               btn_left_p0;
  logic               btn_right_p0;
  logic               btn_up_p0;
  logic               btn_down_p0;
  logic [COORD_W-1:0] x_clamped;
  logic [COORD_W-1:0] y_clamped;
  logic               x_at_max;
  logic               x_at_min;
  logic               y_at_max;
  logic               y_at_min;

  // tick_qual ignores state so a busy-time tick can still be flagged as overrun
  assign div_last  = (div_cnt == DIV_W'(FRAME_DIV - 1));
  assign tick_qual = frame_tick && enable && div_last;
  assign accept    = (state == IDLE) && tick_qual;
  assign vld_p0    = (state == COMMIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = CLAMP;
      CLAMP:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      pos_x       <= COORD_W'(INIT_X);
      pos_y       <= COORD_W'(INIT_Y);
      collision   <= 4'b0000;
    end else begin
      state       <= state_next;
      update_done <= vld_p0;
      overrun     <= (state != IDLE) && tick_qual;
      if ((state == IDLE) && enable && frame_tick)
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (vld_p0) begin
        pos_x                 <= x_clamped;
        pos_y                 <= y_clamped;
        collision[COL_RIGHT]  <= x_at_max;
        collision[COL_LEFT]   <= x_at_min;
        collision[COL_BOTTOM] <= y_at_max;
        collision[COL_TOP]    <= y_at_min;
      end
    end
  end

  // Stage p0: button snapshot taken with the accepted tick
  always_ff @(posedge clk) begin
    if (accept) begin
      btn_left_p0  <= btn_left;
      btn_right_p0 <= btn_right;
      btn_up_p0    <= btn_up;
      btn_down_p0  <= btn_down;
    end
  end

  axis_step_clamp #(.MAX(XMAX), .STEP(STEP)) u_axis_x (
    .clk         (clk),
    .calc_en     (state == CALC),
    .clamp_en    (state == CLAMP),
    .pos         (pos_x),
    .inc         (btn_right_p0),
    .dec         (btn_left_p0),
    .pos_clamped (x_clamped),
    .at_max      (x_at_max),
    .at_min      (x_at_min)
  );

  axis_step_clamp #(.MAX(YMAX), .STEP(STEP)) u_axis_y (
    .clk         (clk),
    .calc_en     (state == CALC),
    .clamp_en    (state == CLAMP),
    .pos         (pos_y),
    .inc         (btn_down_p0),
    .dec         (btn_up_p0),
    .pos_clamped (y_clamped),
    .at_max      (y_at_max),
    .at_min      (y_at_min)
  );

endmodule
